// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures one record per committed instruction into a
// small FIFO, tags it with a running instruction number and streams it out on
// a valid/ready port. After a HALT retires, the buffer drains and raises done.
module retire_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit,
    input  logic [15:0] pc,
    input  logic [15:0] inst,
    input  logic        reg_write,
    input  logic [2:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        halt,
    output logic        full,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_inum,
    output logic [86:0] out_rec,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic        done
);

    localparam int RW = 87;          // record width
    localparam int EW = 16 + RW;     // stored entry: {inum, record}
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   inum_q, inum_d;
    logic [7:0]    drop_q, drop_d;
    state_t        state_q, state_d;
    logic          full_q, valid_q, overflow_q, done_q;
    logic          pop, push, drop;
    logic [RW-1:0] rec_in;
    logic [EW-1:0] head;

    assign rec_in = {pc, inst, reg_write, write_reg, write_data,
                     mem_read, mem_write, mem_addr, mem_data, halt};

    // Next-state computation for pointers, occupancy, numbering and FSM.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pop      = valid_q && out_ready;
        push     = 1'b0;
        drop     = 1'b0;
        inum_d   = inum_q;
        drop_d   = drop_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;

        // A full FIFO still accepts a commit if a pop frees a slot this cycle.
        if (state_q == S_RUN && commit) begin
            inum_d = inum_q + 16'd1;
            if (!full_q || pop) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        case (state_q)
            S_RUN:   if (commit && halt) state_d = S_DRAIN;
            S_DRAIN: if (count_d == '0) state_d = S_DONE;
            default: state_d = S_DONE;
        endcase
    end

    // Control state, FSM and registered status outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inum_q     <= '0;
            drop_q     <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inum_q     <= inum_d;
            drop_q     <= drop_d;
            full_q     <= (count_d == DEPTH_C);
            valid_q    <= (count_d != '0);
            overflow_q <= overflow_q | drop;
            done_q     <= (state_d == S_DONE);
        end
    end

    // Record storage.
    // NOTE: the storage array has no reset; validity is tracked by count_q,
    // so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {inum_q, rec_in};
        end
    end

    // Head entry is read from registered storage, so nothing falls through
    // in the cycle of the push; it is masked to zero while empty.
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = valid_q;
    assign out_inum  = valid_q ? head[EW-1:RW] : 16'd0;
    assign out_rec   = valid_q ? head[RW-1:0] : '0;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;
    assign done      = done_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: a behavioural occupancy model predicts every
// accepted record into a scoreboard; a negedge monitor compares the head and
// the status outputs against it each cycle.
module tb_retire_trace_buffer;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
        logic        reg_write;
        logic [2:0]  write_reg;
        logic [15:0] write_data;
        logic        mem_read;
        logic        mem_write;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
        logic        halt;
    } rec_t;

    typedef struct {
        logic [15:0] inum;
        rec_t        rec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit = 1'b0;
    logic        out_ready = 1'b0;
    rec_t        cur = '0;
    logic        full, out_valid, overflow, done;
    logic [15:0] out_inum;
    logic [86:0] out_rec;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model state
    exp_t        sb[$];
    int          m_cnt = 0;
    logic [15:0] m_inum = 0;
    int          m_mode = 0;   // 0 running, 1 draining, 2 finished
    bit          m_ovf = 0;
    int          m_drops = 0;

    retire_trace_buffer #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .commit(commit),
        .pc(cur.pc), .inst(cur.inst), .reg_write(cur.reg_write),
        .write_reg(cur.write_reg), .write_data(cur.write_data),
        .mem_read(cur.mem_read), .mem_write(cur.mem_write),
        .mem_addr(cur.mem_addr), .mem_data(cur.mem_data), .halt(cur.halt),
        .full(full), .out_valid(out_valid), .out_ready(out_ready),
        .out_inum(out_inum), .out_rec(out_rec), .overflow(overflow),
        .drop_cnt(drop_cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t rand_rec();
        rec_t r;
        r.pc         = 16'($urandom);
        r.inst       = 16'($urandom);
        r.reg_write  = 1'($urandom);
        r.write_reg  = 3'($urandom);
        r.write_data = 16'($urandom);
        r.mem_read   = 1'($urandom);
        r.mem_write  = 1'($urandom);
        r.mem_addr   = 16'($urandom);
        r.mem_data   = 16'($urandom);
        r.halt       = 1'b0;
        return r;
    endfunction

    // Model of one clock edge, derived from the buffer's rules on occupancy.
    task automatic model_edge();
        bit pop, psh, was_drain;
        if (!rst_n) begin
            sb.delete();
            m_cnt = 0; m_inum = 0; m_mode = 0; m_ovf = 0; m_drops = 0;
        end else begin
            pop = (m_cnt > 0) && out_ready;
            psh = 1'b0;
            was_drain = (m_mode == 1);
            if (m_mode == 0 && commit) begin
                if (m_cnt < DEPTH || pop) begin
                    psh = 1'b1;
                    sb.push_back('{inum: m_inum, rec: cur});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
                m_inum = m_inum + 16'd1;
                if (cur.halt) m_mode = 1;
            end
            m_cnt = m_cnt + int'(psh) - int'(pop);
            if (was_drain && m_cnt == 0) m_mode = 2;
        end
    endtask

    task automatic step(input bit rst, input bit c, input bit rdy, input rec_t r);
        rst_n = rst; commit = c; out_ready = rdy; cur = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (m_cnt != 0 && n < max_cycles) begin
            step(1'b1, 1'b0, 1'b1, rand_rec());
            n++;
        end
        check("drain_bound", (m_cnt == 0), 1'b1);
    endtask

    // Monitor: head and status compared against the model every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", out_valid, (m_cnt != 0));
            check("full", full, (m_cnt == DEPTH));
            check("overflow", overflow, m_ovf);
            check("drop_cnt", drop_cnt, 8'(m_drops));
            check("done", done, (m_mode == 2));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_record", out_valid, 1'b0);
                end else begin
                    check("out_inum", out_inum, sb[0].inum);
                    check("out_rec", out_rec, sb[0].rec);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        int   d0;

        // Reset
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        mon_en = 1'b1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_cnt", drop_cnt, 8'd0);
        check("rst_done", done, 1'b0);
        check("rst_inum", out_inum, 16'd0);
        check("rst_rec", out_rec, 87'd0);

        // 1: three register-writing commits, consumer always ready
        for (int i = 0; i < 3; i++) begin
            r = '0;
            r.pc = 16'(2 * i);
            r.inst = 16'($urandom);
            r.reg_write = 1'b1;
            r.write_reg = 3'd1;
            r.write_data = 16'h0005;
            step(1'b1, 1'b1, 1'b1, r);
            if (i == 0) check("t1_valid_next_cycle", out_valid, 1'b1);
        end
        drain(20);

        // 2: fill with consumer stalled, two drops, then resume
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, rand_rec());
            if (i == 7) check("t2_full_after_8", full, 1'b1);
        end
        check("t2_drop_cnt", drop_cnt, 8'd2);
        check("t2_overflow", overflow, 1'b1);
        drain(20);
        step(1'b1, 1'b1, 1'b0, rand_rec());
        check("t2_inum_after_gap", out_inum, 16'd10);
        drain(20);

        // 3: full FIFO with simultaneous pop and push
        while (m_cnt < DEPTH) step(1'b1, 1'b1, 1'b0, rand_rec());
        d0 = m_drops;
        step(1'b1, 1'b1, 1'b1, rand_rec());
        check("t3_full_kept", full, 1'b1);
        check("t3_no_drop", drop_cnt, 8'(d0));
        drain(20);

        // 5: alternating backpressure, then fully random traffic
        for (int i = 0; i < 200; i++)
            step(1'b1, ($urandom_range(3) != 0), ~i[0], rand_rec());
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'($urandom), 1'($urandom), rand_rec());
        drain(40);

        // 4: store then halt, later commits ignored, drain to done
        r = rand_rec();
        r.mem_write = 1'b1; r.mem_addr = 16'h0010; r.mem_data = 16'hBEEF;
        step(1'b1, 1'b1, 1'b0, r);
        r = rand_rec();
        r.pc = 16'h0006; r.halt = 1'b1;
        step(1'b1, 1'b1, 1'b0, r);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'($urandom), rand_rec());
        drain(20);
        check("t4_done", done, 1'b1);
        step(1'b1, 1'b1, 1'b1, rand_rec());
        check("t4_done_holds", done, 1'b1);
        check("t4_ignored", out_valid, 1'b0);

        // 6: reset while draining four entries
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            r = rand_rec();
            r.halt = (i == 3);
            step(1'b1, 1'b1, 1'b0, r);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        check("t6_valid", out_valid, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_overflow", overflow, 1'b0);
        step(1'b1, 1'b1, 1'b0, rand_rec());
        check("t6_inum0", out_inum, 16'd0);
        drain(20);

        step(1'b1, 1'b0, 1'b0, '0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
